opsum_drain_arb_ctrl: RTL and testbench
=======================================

OPSUM_DRAIN_ARB_CTRL -- requirements
Module: opsum_drain_arb_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of opsum FIFO channels sharing one GLB write port.
REQ-002 Parameter ADDR_W, default 32: GLB address width.
REQ-003 Parameter PTR_W, default 16: per-channel write pointer width.
REQ-004 Parameter CNT_W, default 8: drain length counter width.
REQ-005 clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-006 fifo_reset_i  in  1  layer-level clear; fifo_reset_o  out  1  combinational copy to all FIFOs.
REQ-007 push_req_i  in  NUM_CH  reducer has data for channel c; fifo_full_i  in  NUM_CH  per-channel full.
REQ-008 fifo_push_en_o  out  NUM_CH  per-channel push strobe.
REQ-009 drain_start_i  in  NUM_CH  start drain on channel c; drain_len_i  in  CNT_W  words to drain, shared.
REQ-010 fifo_empty_i  in  NUM_CH  per-channel empty; fifo_pop_en_o  out  NUM_CH  per-channel pop strobe, one-hot or zero.
REQ-011 glb_base_addr_i  in  ADDR_W  layer base; ch_stride_i  in  ADDR_W  address gap between channel regions.
REQ-012 web_i  in  4  byte enables for current layer.
REQ-013 glb_write_req_o  out  1; glb_permit_i  in  1  arbiter grant; glb_write_addr_o  out  ADDR_W; glb_write_web_o  out  4; glb_ch_o  out  $clog2(NUM_CH)  selected channel.
REQ-014 drain_done_o  out  NUM_CH  one-cycle done pulse; cmd_err_o  out  1  one-cycle illegal-start pulse; busy_o  out  1  any channel draining.

Function
REQ-015 fifo_push_en_o[c] SHALL equal push_req_i[c] & ~fifo_full_i[c], combinational, independent of drain state.
REQ-016 Each channel SHALL have a two-state FSM IDLE/DRAIN plus remaining counter rem[c] (CNT_W) and pointer ptr[c] (PTR_W).
REQ-017 IDLE with drain_start_i[c] and drain_len_i>0 SHALL load rem[c]=drain_len_i and enter DRAIN next cycle.
REQ-018 IDLE with drain_start_i[c] and drain_len_i==0 SHALL stay IDLE and pulse drain_done_o[c] the following cycle.
REQ-019 drain_start_i[c] while channel c is in DRAIN (including its final transfer cycle) SHALL be ignored and pulse cmd_err_o next cycle.
REQ-020 Channel c is eligible when in DRAIN and ~fifo_empty_i[c]; glb_write_req_o SHALL equal OR of eligibility, combinational.
REQ-021 Selection SHALL be round-robin among eligible channels, searching from (last_accepted+1) mod NUM_CH; last_accepted resets to NUM_CH-1.
REQ-022 glb_ch_o, glb_write_addr_o, glb_write_web_o SHALL reflect the selected channel in the same cycle; when no request, glb_ch_o=0 and address is don't-care.
REQ-023 glb_write_addr_o SHALL be glb_base_addr_i + glb_ch_o*ch_stride_i + zero-extended ptr[sel], truncated to ADDR_W.
REQ-024 glb_write_web_o SHALL equal web_i.
REQ-025 Transfer accepted when glb_write_req_o & glb_permit_i: fifo_pop_en_o[sel]=1 that cycle, zero-latency; all other pop bits 0.
REQ-026 On accept: ptr[sel]+=1 modulo 2^PTR_W (wrap, no flag), rem[sel]-=1, last_accepted=sel.
REQ-027 When accept makes rem[sel]==0, channel SHALL return to IDLE and pulse drain_done_o[sel] next cycle.
REQ-028 permit without request SHALL have no effect; request SHALL hold until permit, selection may change only if eligibility changes.
REQ-029 busy_o SHALL be OR of DRAIN states, registered.
REQ-030 fifo_reset_i SHALL, next edge, force all channels IDLE, rem=0, ptr=0, last_accepted=NUM_CH-1, suppress pending done/err pulses; it has priority over drain_start_i and accepts.

Reset
REQ-031 rst_n low SHALL asynchronously clear all state identically to REQ-030; all registered outputs 0.
REQ-032 Reset mid-drain SHALL abandon the drain without a done pulse.

Structure
REQ-033 A shared package opsum_pkg SHALL hold the IDLE/DRAIN state enum and default parameter constants.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (parameter N; inputs req, last; outputs grant one-hot, valid, index).

Verification
REQ-035 NUM_CH=4, start ch1 len=3, permit always, FIFO non-empty -> 3 pops on ch1 in consecutive cycles, addr base+stride+0/1/2, drain_done_o[1] pulse after third.
REQ-036 Channels 0,2,3 draining len=2, permit always -> accept order 0,2,3,0,2,3; busy_o drops after last.
REQ-037 ch0 draining, fifo_empty_i[0] toggles, permit held -> pops only when non-empty; rem counts only accepts.
REQ-038 start ch2 len=0 -> no request, drain_done_o[2] pulse next cycle; start ch2 again during DRAIN -> cmd_err_o pulse, rem unchanged.
REQ-039 ptr[0]=0xFFFF (PTR_W=16), one accept -> ptr wraps to 0, address base+0.
REQ-040 fifo_reset_i (then rst_n) asserted mid-drain -> all pops stop, ptr=0, no done pulse, busy_o=0.

Source files
------------

// File: rtl/opsum_pkg.sv
// Shared types and default sizing for the opsum drain arbitration controller.
package opsum_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_PTR_W  = 16;
  localparam int unsigned DEF_CNT_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first requester found searching upward from last_i+1 (mod N).
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic          valid_o,
  output logic [IW-1:0] index_o
);

  logic [IW-1:0] cand;

  // Walk the candidates farthest-first so the nearest one after last_i wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        valid_o       = 1'b1;
        index_o       = cand;
      end
    end
  end

endmodule

// File: rtl/opsum_drain_arb_ctrl.sv
// Drains several opsum FIFO channels through one shared GLB write port, one word per
// granted cycle, with a per-channel IDLE/DRAIN controller, length counter and address pointer.
module opsum_drain_arb_ctrl
  import opsum_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PTR_W  = DEF_PTR_W,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_reset_i,
  output logic              fifo_reset_o,
  input  logic [NUM_CH-1:0] push_req_i,
  input  logic [NUM_CH-1:0] fifo_full_i,
  output logic [NUM_CH-1:0] fifo_push_en_o,
  input  logic [NUM_CH-1:0] drain_start_i,
  input  logic [CNT_W-1:0]  drain_len_i,
  input  logic [NUM_CH-1:0] fifo_empty_i,
  output logic [NUM_CH-1:0] fifo_pop_en_o,
  input  logic [ADDR_W-1:0] glb_base_addr_i,
  input  logic [ADDR_W-1:0] ch_stride_i,
  input  logic [3:0]        web_i,
  output logic              glb_write_req_o,
  input  logic              glb_permit_i,
  output logic [ADDR_W-1:0] glb_write_addr_o,
  output logic [3:0]        glb_write_web_o,
  output logic [CH_W-1:0]   glb_ch_o,
  output logic [NUM_CH-1:0] drain_done_o,
  output logic              cmd_err_o,
  output logic              busy_o
);

  drain_state_e      state_q [NUM_CH];
  drain_state_e      state_d [NUM_CH];
  logic [CNT_W-1:0]  rem_q   [NUM_CH];
  logic [CNT_W-1:0]  rem_d   [NUM_CH];
  logic [PTR_W-1:0]  ptr_q   [NUM_CH];
  logic [PTR_W-1:0]  ptr_d   [NUM_CH];
  logic [CH_W-1:0]   last_q, last_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;
  logic              sel_valid;
  logic [CH_W-1:0]   sel_idx;
  logic              accept;

  assign fifo_reset_o   = fifo_reset_i;
  assign fifo_push_en_o = push_req_i & ~fifo_full_i;

  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = (state_q[c] == ST_DRAIN) & ~fifo_empty_i[c];
    end
  end

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req_i   (elig),
    .last_i  (last_q),
    .grant_o (grant),
    .valid_o (sel_valid),
    .index_o (sel_idx)
  );

  assign accept           = sel_valid & glb_permit_i;
  assign glb_write_req_o  = sel_valid;
  assign glb_ch_o         = sel_valid ? sel_idx : '0;
  assign glb_write_web_o  = web_i;
  assign fifo_pop_en_o    = accept ? grant : '0;
  assign glb_write_addr_o = glb_base_addr_i + ADDR_W'(glb_ch_o) * ch_stride_i
                          + ADDR_W'(ptr_q[glb_ch_o]);

  // A start on a draining channel only raises an error; the transfer in that cycle still counts.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (drain_start_i[c]) begin
        if (state_q[c] == ST_DRAIN) begin
          err_d = 1'b1;
        end else if (drain_len_i == '0) begin
          done_d[c] = 1'b1;
        end else begin
          state_d[c] = ST_DRAIN;
          rem_d[c]   = drain_len_i;
        end
      end
      if (accept && grant[c]) begin
        ptr_d[c] = ptr_q[c] + PTR_W'(1);
        rem_d[c] = rem_q[c] - CNT_W'(1);
        last_d   = CH_W'(c);
        if (rem_q[c] == CNT_W'(1)) begin
          state_d[c] = ST_IDLE;
          done_d[c]  = 1'b1;
        end
      end
    end
    if (fifo_reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_d[c] = ST_IDLE;
        rem_d[c]   = '0;
        ptr_d[c]   = '0;
      end
      last_d = CH_W'(NUM_CH - 1);
      done_d = '0;
      err_d  = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      busy_d = busy_d | (state_d[c] == ST_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        rem_q[c]   <= '0;
        ptr_q[c]   <= '0;
      end
      last_q <= CH_W'(NUM_CH - 1);
      done_q <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign drain_done_o = done_q;
  assign cmd_err_o    = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_opsum_drain_arb_ctrl.sv
// Bench for opsum_drain_arb_ctrl: directed scenarios plus random traffic, each cycle
// compared against a queue/array model of the drain rules.
module tb_opsum_drain_arb_ctrl;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int PTR_W  = 16;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam logic [ADDR_W-1:0] BASE   = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] STRIDE = 32'h0000_4000;

  logic              clk;
  logic              rst_n;
  logic              fifo_reset_i, fifo_reset_o;
  logic [NUM_CH-1:0] push_req_i, fifo_full_i, fifo_push_en_o;
  logic [NUM_CH-1:0] drain_start_i;
  logic [CNT_W-1:0]  drain_len_i;
  logic [NUM_CH-1:0] fifo_empty_i, fifo_pop_en_o;
  logic [ADDR_W-1:0] glb_base_addr_i, ch_stride_i;
  logic [3:0]        web_i;
  logic              glb_write_req_o, glb_permit_i;
  logic [ADDR_W-1:0] glb_write_addr_o;
  logic [3:0]        glb_write_web_o;
  logic [CH_W-1:0]   glb_ch_o;
  logic [NUM_CH-1:0] drain_done_o;
  logic              cmd_err_o, busy_o;

  opsum_drain_arb_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_reset_i     (fifo_reset_i),
    .fifo_reset_o     (fifo_reset_o),
    .push_req_i       (push_req_i),
    .fifo_full_i      (fifo_full_i),
    .fifo_push_en_o   (fifo_push_en_o),
    .drain_start_i    (drain_start_i),
    .drain_len_i      (drain_len_i),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_pop_en_o    (fifo_pop_en_o),
    .glb_base_addr_i  (glb_base_addr_i),
    .ch_stride_i      (ch_stride_i),
    .web_i            (web_i),
    .glb_write_req_o  (glb_write_req_o),
    .glb_permit_i     (glb_permit_i),
    .glb_write_addr_o (glb_write_addr_o),
    .glb_write_web_o  (glb_write_web_o),
    .glb_ch_o         (glb_ch_o),
    .drain_done_o     (drain_done_o),
    .cmd_err_o        (cmd_err_o),
    .busy_o           (busy_o)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  bit                m_drn  [NUM_CH];
  int                m_rem  [NUM_CH];
  int                m_ptr  [NUM_CH];
  int                m_last;
  logic [NUM_CH-1:0] m_done;
  bit                m_err;
  bit                e_req;
  int                e_sel;
  logic [ADDR_W-1:0] e_addr;
  logic [NUM_CH-1:0] e_pop;

  logic [CH_W-1:0]   got_ch_q   [$];
  logic [ADDR_W-1:0] got_addr_q [$];
  logic [CH_W-1:0]   exp_q      [$];

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_drn[c] = 0;
      m_rem[c] = 0;
      m_ptr[c] = 0;
    end
    m_last = NUM_CH - 1;
    m_done = '0;
    m_err  = 0;
  endfunction

  function automatic bit model_busy();
    bit b = 0;
    for (int c = 0; c < NUM_CH; c++) b |= m_drn[c];
    return b;
  endfunction

  function automatic void model_eval();
    e_req = 0;
    e_sel = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int c = (m_last + k) % NUM_CH;
      if (!e_req && m_drn[c] && !fifo_empty_i[c]) begin
        e_req = 1;
        e_sel = c;
      end
    end
    e_addr = glb_base_addr_i + 32'(e_sel) * ch_stride_i + 32'(m_ptr[e_sel]);
    e_pop  = (e_req && glb_permit_i) ? NUM_CH'(1 << e_sel) : '0;
  endfunction

  function automatic void model_update();
    logic [NUM_CH-1:0] nd = '0;
    bit                ne = 0;
    if (!rst_n || fifo_reset_i) begin
      model_clear();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (drain_start_i[c]) begin
        if (m_drn[c]) ne = 1;
        else if (drain_len_i == 0) nd[c] = 1'b1;
        else begin
          m_drn[c] = 1;
          m_rem[c] = int'(drain_len_i);
        end
      end
    end
    if (e_pop != 0) begin
      m_ptr[e_sel] = (m_ptr[e_sel] + 1) % (1 << PTR_W);
      m_rem[e_sel] = m_rem[e_sel] - 1;
      m_last       = e_sel;
      if (m_rem[e_sel] == 0) begin
        m_drn[e_sel] = 0;
        nd[e_sel]    = 1'b1;
      end
    end
    m_done = nd;
    m_err  = ne;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    check("push_en", 64'(fifo_push_en_o), 64'(push_req_i & ~fifo_full_i));
    check("fifo_reset_o", 64'(fifo_reset_o), 64'(fifo_reset_i));
    check("write_req", 64'(glb_write_req_o), 64'(e_req));
    check("glb_ch", 64'(glb_ch_o), 64'(e_sel));
    if (e_req) check("write_addr", 64'(glb_write_addr_o), 64'(e_addr));
    check("write_web", 64'(glb_write_web_o), 64'(web_i));
    check("pop_en", 64'(fifo_pop_en_o), 64'(e_pop));
    check("drain_done", 64'(drain_done_o), 64'(m_done));
    check("cmd_err", 64'(cmd_err_o), 64'(m_err));
    check("busy", 64'(busy_o), 64'(model_busy()));
    if (fifo_pop_en_o != 0) begin
      got_ch_q.push_back(glb_ch_o);
      got_addr_q.push_back(glb_write_addr_o);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    fifo_reset_i    = 1'b0;
    push_req_i      = '0;
    fifo_full_i     = '0;
    drain_start_i   = '0;
    drain_len_i     = '0;
    fifo_empty_i    = '0;
    glb_permit_i    = 1'b0;
    glb_base_addr_i = BASE;
    ch_stride_i     = STRIDE;
    web_i           = 4'hF;
  endtask

  task automatic start_drain(input logic [NUM_CH-1:0] chs, input int len);
    drain_start_i = chs;
    drain_len_i   = CNT_W'(len);
    tick();
    drain_start_i = '0;
  endtask

  task automatic layer_clear();
    fifo_reset_i = 1'b1;
    tick();
    fifo_reset_i = 1'b0;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] exp_push;
  } push_vec_t;

  push_vec_t push_tbl [6];

  initial begin
    int pops, bad_pops;

    push_tbl[0] = '{4'b0000, 4'b0000, 4'b0000};
    push_tbl[1] = '{4'b1111, 4'b0000, 4'b1111};
    push_tbl[2] = '{4'b1111, 4'b1111, 4'b0000};
    push_tbl[3] = '{4'b1010, 4'b0010, 4'b1000};
    push_tbl[4] = '{4'b0101, 4'b1100, 4'b0001};
    push_tbl[5] = '{4'b0110, 4'b1001, 4'b0110};

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Push gating table, with a drain active to show independence from drain state
    start_drain(4'b0001, 3);
    for (int i = 0; i < 6; i++) begin
      push_req_i  = push_tbl[i].req;
      fifo_full_i = push_tbl[i].full;
      #1;
      check("push_tbl", 64'(fifo_push_en_o), 64'(push_tbl[i].exp_push));
      tick();
    end
    push_req_i  = '0;
    fifo_full_i = '0;
    layer_clear();

    // ch1 len=3, permit held: three back-to-back pops at base+stride+0/1/2
    glb_permit_i = 1'b1;
    start_drain(4'b0010, 3);
    got_ch_q.delete();
    got_addr_q.delete();
    for (int i = 0; i < 3; i++) tick();
    check("seq1_pops", 64'(got_addr_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < got_addr_q.size(); i++) begin
      check("seq1_addr", 64'(got_addr_q[i]), 64'(BASE + STRIDE + 32'(i)));
      check("seq1_ch", 64'(got_ch_q[i]), 64'd1);
    end
    check("seq1_done", 64'(drain_done_o), 64'b0010);
    check("seq1_busy", 64'(busy_o), 64'd0);
    tick();

    // Channels 0,2,3 len=2 after a layer clear: round-robin 0,2,3,0,2,3
    layer_clear();
    start_drain(4'b1101, 2);
    got_ch_q.delete();
    for (int i = 0; i < 6; i++) tick();
    exp_q = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    check("rr_count", 64'(got_ch_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_ch_q.size(); i++)
      check("rr_order", 64'(got_ch_q[i]), 64'(exp_q[i]));
    check("rr_busy", 64'(busy_o), 64'd0);
    tick();

    // ch0 with empty toggling: pops only on non-empty cycles
    start_drain(4'b0001, 3);
    pops = 0;
    bad_pops = 0;
    for (int i = 0; i < 10; i++) begin
      fifo_empty_i[0] = (i % 2 == 0);
      #1;
      if (fifo_empty_i[0] && fifo_pop_en_o[0]) bad_pops++;
      if (fifo_pop_en_o[0]) pops++;
      tick();
    end
    fifo_empty_i = '0;
    check("empty_pops", 64'(bad_pops), 64'd0);
    check("toggle_pops", 64'(pops), 64'd3);

    // Zero-length start, then a start while draining
    start_drain(4'b0100, 0);
    check("len0_done", 64'(drain_done_o), 64'b0100);
    check("len0_req", 64'(glb_write_req_o), 64'd0);
    tick();
    glb_permit_i = 1'b0;
    start_drain(4'b0100, 2);
    start_drain(4'b0100, 5);
    check("restart_err", 64'(cmd_err_o), 64'd1);
    glb_permit_i = 1'b1;
    got_ch_q.delete();
    for (int i = 0; i < 5; i++) tick();
    check("restart_pops", 64'(got_ch_q.size()), 64'd2);

    // Layer clear mid-drain
    start_drain(4'b1010, 10);
    tick();
    tick();
    layer_clear();
    check("clr_busy", 64'(busy_o), 64'd0);
    check("clr_done", 64'(drain_done_o), 64'd0);
    got_ch_q.delete();
    got_addr_q.delete();
    for (int i = 0; i < 3; i++) tick();
    check("clr_nopops", 64'(got_ch_q.size()), 64'd0);
    start_drain(4'b0010, 1);
    tick();
    check("clr_ptr0", (got_addr_q.size() == 1) ? 64'(got_addr_q[0]) : 64'hdead,
          64'(BASE + STRIDE));

    // Asynchronous reset mid-drain
    start_drain(4'b0001, 10);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_pop", 64'(fifo_pop_en_o), 64'd0);
    check("rst_req", 64'(glb_write_req_o), 64'd0);
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_done", 64'(drain_done_o), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      fifo_reset_i    = ($urandom_range(0, 99) == 0);
      push_req_i      = NUM_CH'($urandom);
      fifo_full_i     = NUM_CH'($urandom);
      drain_start_i   = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : '0;
      drain_len_i     = CNT_W'($urandom_range(0, 4));
      fifo_empty_i    = NUM_CH'($urandom) & NUM_CH'($urandom);
      glb_permit_i    = ($urandom_range(0, 3) != 0);
      glb_base_addr_i = $urandom;
      ch_stride_i     = $urandom;
      web_i           = 4'($urandom);
      tick();
    end
    drive_idle();

    // Pointer wrap: 65535 accepts on ch0, then two more cross 0xFFFF -> 0
    glb_permit_i = 1'b1;
    layer_clear();
    for (int d = 0; d < 257; d++) begin
      start_drain(4'b0001, 255);
      for (int i = 0; i < 255; i++) tick();
    end
    got_addr_q.delete();
    start_drain(4'b0001, 2);
    tick();
    tick();
    check("wrap_count", 64'(got_addr_q.size()), 64'd2);
    if (got_addr_q.size() == 2) begin
      check("wrap_ffff", 64'(got_addr_q[0]), 64'(BASE + 32'h0000_FFFF));
      check("wrap_zero", 64'(got_addr_q[1]), 64'(BASE));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
